// File: rtl/dvb_pls_enc_pkg.sv
// Shared PLS definitions: code/codeword types, the default scrambling sequence
// and the first-order Reed-Muller (32,6) row masks used by encoder and decoder tables.
package dvb_pls_enc_pkg;

    typedef logic [6:0]  pls_code_t;
    typedef logic [63:0] pls_cw_t;

    localparam pls_cw_t cPLS_SCR_SEQ = 64'h719D83C953422DFA;

    localparam logic [0:0] cST_IDLE = 1'b0;
    localparam logic [0:0] cST_RUN  = 1'b1;

    // Row r of the RM generator: bit j set when code bit r contributes to y[j].
    // Row 0 is the all-ones row; rows 1..5 select j[4]..j[0] respectively.
    function automatic logic [31:0] pls_rm_row(input logic [2:0] row);
        logic [31:0] mask;
        logic [4:0]  jv;
        mask = 32'h0000_0000;
        for (int j = 0; j < 32; j++) begin
            jv = 5'(j);
            case (row)
                3'd0:    mask[j] = 1'b1;
                3'd1:    mask[j] = jv[4];
                3'd2:    mask[j] = jv[3];
                3'd3:    mask[j] = jv[2];
                3'd4:    mask[j] = jv[1];
                3'd5:    mask[j] = jv[0];
                default: mask[j] = 1'b0;
            endcase
        end
        return mask;
    endfunction

endpackage

// File: rtl/dvb_pls_enc_rm.sv
// Combinational PLS codeword builder: RM(32,6) on code[5:0], then the (y, y^code[6])
// pair interleave. cw[63-k] carries transmitted bit k.
module dvb_pls_enc_rm
    import dvb_pls_enc_pkg::*;
(
    input  logic [6:0]  code,
    output logic [63:0] cw
);

    logic [31:0] y_s;

    // RM encode as XOR of the selected generator rows, then interleave into transmit order.
    always_comb begin
        y_s = 32'h0000_0000;
        cw  = 64'h0;
        for (int i = 0; i < 6; i++) begin
            y_s = y_s ^ (pls_rm_row(3'(i)) & {32{code[i]}});
        end
        for (int j = 0; j < 32; j++) begin
            cw[63 - 2*j] = y_s[j];
            cw[62 - 2*j] = y_s[j] ^ code[6];
        end
    end

endmodule

// File: rtl/dvb_pls_enc.sv
// DVB-S2 PLS encoder: accepts one 7-bit code, emits a 64-bit scrambled codeword
// MSB first with sop/val/eop framing and a pi/2-BPSK phase flag.
module dvb_pls_enc
    import dvb_pls_enc_pkg::*;
#(
    parameter bit          pSCRAMBLE = 1'b1,
    parameter logic [63:0] pSCR_SEQ  = cPLS_SCR_SEQ
)(
    input  logic        iclk,
    input  logic        ireset,
    input  logic        iclkena,
    input  logic        ival,
    input  logic [6:0]  idat,
    output logic        ordy,
    output logic        osop,
    output logic        oval,
    output logic        oeop,
    output logic        odat,
    output logic        ophase,
    output logic [63:0] ocw
);

    logic [0:0]  state_r, state_nxt_s;
    logic [5:0]  cnt_r, cnt_nxt_s;
    logic [63:0] sh_r, sh_nxt_s;
    logic [63:0] ocw_r, ocw_nxt_s;
    logic        rdy_r, rdy_nxt_s;
    logic        sop_r, sop_nxt_s;
    logic        val_r, val_nxt_s;
    logic        eop_r, eop_nxt_s;
    logic        dat_r, dat_nxt_s;
    logic        phase_r, phase_nxt_s;
    logic        accept_s;
    logic [63:0] cw_s;
    logic [63:0] scr_s;

    dvb_pls_enc_rm u_rm (
        .code (idat),
        .cw   (cw_s)
    );

    assign scr_s    = cw_s ^ (pSCRAMBLE ? pSCR_SEQ : 64'h0);
    assign accept_s = ival & rdy_r & iclkena;

    // Next-state decode: a new accept always wins, which gives back-to-back frames on the eop cycle.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        sh_nxt_s    = sh_r;
        ocw_nxt_s   = ocw_r;
        rdy_nxt_s   = rdy_r;
        sop_nxt_s   = sop_r;
        val_nxt_s   = val_r;
        eop_nxt_s   = eop_r;
        dat_nxt_s   = dat_r;
        phase_nxt_s = phase_r;
        if (accept_s) begin
            state_nxt_s = cST_RUN;
            cnt_nxt_s   = 6'd0;
            sh_nxt_s    = {scr_s[62:0], 1'b0};
            ocw_nxt_s   = scr_s;
            rdy_nxt_s   = 1'b0;
            sop_nxt_s   = 1'b1;
            val_nxt_s   = 1'b1;
            eop_nxt_s   = 1'b0;
            dat_nxt_s   = scr_s[63];
            phase_nxt_s = 1'b0;
        end else begin
            case (state_r)
                cST_RUN: begin
                    if (cnt_r == 6'd63) begin
                        state_nxt_s = cST_IDLE;
                        cnt_nxt_s   = 6'd0;
                        rdy_nxt_s   = 1'b1;
                        sop_nxt_s   = 1'b0;
                        val_nxt_s   = 1'b0;
                        eop_nxt_s   = 1'b0;
                        dat_nxt_s   = 1'b0;
                        phase_nxt_s = 1'b0;
                    end else begin
                        cnt_nxt_s   = cnt_r + 6'd1;
                        sh_nxt_s    = {sh_r[62:0], 1'b0};
                        dat_nxt_s   = sh_r[63];
                        sop_nxt_s   = 1'b0;
                        val_nxt_s   = 1'b1;
                        eop_nxt_s   = (cnt_r == 6'd62);
                        rdy_nxt_s   = (cnt_r == 6'd62);
                        phase_nxt_s = ~cnt_r[0];
                    end
                end
                cST_IDLE: begin
                    state_nxt_s = cST_IDLE;
                    cnt_nxt_s   = 6'd0;
                    rdy_nxt_s   = 1'b1;
                    sop_nxt_s   = 1'b0;
                    val_nxt_s   = 1'b0;
                    eop_nxt_s   = 1'b0;
                    dat_nxt_s   = 1'b0;
                    phase_nxt_s = 1'b0;
                end
                default: begin
                    state_nxt_s = cST_IDLE;
                    cnt_nxt_s   = 6'd0;
                    rdy_nxt_s   = 1'b1;
                    sop_nxt_s   = 1'b0;
                    val_nxt_s   = 1'b0;
                    eop_nxt_s   = 1'b0;
                    dat_nxt_s   = 1'b0;
                    phase_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; everything holds while iclkena is low.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_r <= cST_IDLE;
            cnt_r   <= 6'd0;
            sh_r    <= 64'h0;
            ocw_r   <= 64'h0;
            rdy_r   <= 1'b1;
            sop_r   <= 1'b0;
            val_r   <= 1'b0;
            eop_r   <= 1'b0;
            dat_r   <= 1'b0;
            phase_r <= 1'b0;
        end else if (iclkena) begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            sh_r    <= sh_nxt_s;
            ocw_r   <= ocw_nxt_s;
            rdy_r   <= rdy_nxt_s;
            sop_r   <= sop_nxt_s;
            val_r   <= val_nxt_s;
            eop_r   <= eop_nxt_s;
            dat_r   <= dat_nxt_s;
            phase_r <= phase_nxt_s;
        end else begin
            state_r <= state_r;
            cnt_r   <= cnt_r;
            sh_r    <= sh_r;
            ocw_r   <= ocw_r;
            rdy_r   <= rdy_r;
            sop_r   <= sop_r;
            val_r   <= val_r;
            eop_r   <= eop_r;
            dat_r   <= dat_r;
            phase_r <= phase_r;
        end
    end

    assign ordy   = rdy_r;
    assign osop   = sop_r;
    assign oval   = val_r;
    assign oeop   = eop_r;
    assign odat   = dat_r;
    assign ophase = phase_r;
    assign ocw    = ocw_r;

endmodule

// File: tb/tb_dvb_pls_enc.sv
// Self-checking bench for dvb_pls_enc: reference codewords are computed from the
// RM/interleave/scramble equations; the serial stream is captured by a monitor.
module tb_dvb_pls_enc;

    localparam logic [63:0] SEQ = 64'h719D83C953422DFA;

    logic        clk = 1'b0;
    logic        rst;
    logic        iclkena;
    logic        ival;
    logic [6:0]  idat;
    logic        ordy, osop, oval, oeop, odat, ophase;
    logic [63:0] ocw;
    logic        ordy_ns, osop_ns, oval_ns, oeop_ns, odat_ns, ophase_ns;
    logic [63:0] ocw_ns;

    int n_cmp  = 0;
    int n_fail = 0;
    bit gate_on = 1'b0;
    bit inject  = 1'b0;
    bit acc_last;
    logic en_q = 1'b0;
    logic [3:0] q[$];

    always #5 clk = ~clk;

    dvb_pls_enc dut (
        .iclk(clk), .ireset(rst), .iclkena(iclkena), .ival(ival), .idat(idat),
        .ordy(ordy), .osop(osop), .oval(oval), .oeop(oeop), .odat(odat),
        .ophase(ophase), .ocw(ocw)
    );

    dvb_pls_enc #(.pSCRAMBLE(1'b0)) dut_ns (
        .iclk(clk), .ireset(rst), .iclkena(iclkena), .ival(ival), .idat(idat),
        .ordy(ordy_ns), .osop(osop_ns), .oval(oval_ns), .oeop(oeop_ns), .odat(odat_ns),
        .ophase(ophase_ns), .ocw(ocw_ns)
    );

    always @(posedge clk) en_q <= iclkena;

    // Capture one output bit per enabled clock while oval is high.
    always @(negedge clk) begin
        if (en_q && oval) q.push_back({osop, oeop, ophase, odat});
    end

    // Reference codeword, returned with bit k of the transmit order at index 63-k.
    function automatic logic [63:0] model_cw(input logic [6:0] code, input bit scr);
        logic [63:0] r;
        int j, y, c;
        r = 64'h0;
        for (int k = 0; k < 64; k++) begin
            j = k / 2;
            y = code[0] ^ (code[5] & (j % 2)) ^ (code[4] & ((j / 2) % 2)) ^
                (code[3] & ((j / 4) % 2)) ^ (code[2] & ((j / 8) % 2)) ^ (code[1] & ((j / 16) % 2));
            c = (k % 2 == 1) ? (y ^ code[6]) : y;
            r[63-k] = 1'(c) ^ (scr ? SEQ[63-k] : 1'b0);
        end
        return r;
    endfunction

    task automatic tick();
        if (gate_on) iclkena = 1'($urandom_range(0, 1));
        else iclkena = 1'b1;
        acc_last = ival && ordy && iclkena && !rst;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] code);
        bit ok;
        ok = 1'b0;
        ival = 1'b1;
        idat = code;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (acc_last) ok = 1'b1;
        end
        ival = 1'b0;
        idat = 7'($urandom);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout: code %h not accepted, got ordy=%b, required accept", code, ordy);
        end
    endtask

    task automatic check_frame(input logic [6:0] code, input bit chk_ocw);
        logic [63:0] gb, gs, ge, gp, exp;
        logic [3:0] e;
        for (int i = 0; i < 1000 && q.size() < 64; i++) begin
            ival = inject && !ordy && 1'($urandom_range(0, 1));
            idat = 7'($urandom);
            tick();
        end
        ival = 1'b0;
        n_cmp++;
        if (q.size() < 64) begin
            n_fail++;
            $display("FAIL frame_timeout: got %0d bits, required 64", q.size());
        end else begin
            exp = model_cw(code, 1'b1);
            for (int k = 0; k < 64; k++) begin
                e = q.pop_front();
                gs[63-k] = e[3]; ge[63-k] = e[2]; gp[63-k] = e[1]; gb[63-k] = e[0];
            end
            if (gb !== exp) begin
                n_fail++;
                $display("FAIL frame_bits code=%h: got %h required %h", code, gb, exp);
            end
            n_cmp++;
            if (gs !== 64'h8000_0000_0000_0000) begin
                n_fail++;
                $display("FAIL frame_sop code=%h: got %h required 8000000000000000", code, gs);
            end
            n_cmp++;
            if (ge !== 64'h0000_0000_0000_0001) begin
                n_fail++;
                $display("FAIL frame_eop code=%h: got %h required 0000000000000001", code, ge);
            end
            n_cmp++;
            if (gp !== 64'h5555_5555_5555_5555) begin
                n_fail++;
                $display("FAIL frame_phase code=%h: got %h required 5555555555555555", code, gp);
            end
            if (chk_ocw) begin
                n_cmp++;
                if (ocw !== exp) begin
                    n_fail++;
                    $display("FAIL frame_ocw code=%h: got %h required %h", code, ocw, exp);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ival = 1'b0; idat = 7'h00; iclkena = 1'b1;
        #3;
        n_cmp++;
        if ({ordy, osop, oval, oeop, odat, ophase} !== 6'b100000 || ocw !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy/sop/val/eop/dat/ph=%b ocw=%h required 100000 ocw=0",
                     {ordy, osop, oval, oeop, odat, ophase}, ocw);
        end
        @(posedge clk); #1; @(posedge clk); #1;
        rst = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({ordy, oval} !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_after_reset: got rdy/val=%b required 10", {ordy, oval});
        end
    endtask

    task automatic test_known_vectors();
        logic [6:0] codes[3];
        codes[0] = 7'h00; codes[1] = 7'h01; codes[2] = 7'h40;
        for (int i = 0; i < 3; i++) begin
            send(codes[i]);
            check_frame(codes[i], 1'b1);
        end
        n_cmp++;
        if (model_cw(7'h40, 1'b1) !== 64'h24C8D69C061778AF || ocw !== 64'h24C8D69C061778AF) begin
            n_fail++;
            $display("FAIL vector_40: got ocw %h required 24c8d69c061778af", ocw);
        end
    endtask

    task automatic test_all_codes();
        for (int c = 0; c < 128; c++) begin
            send(7'(c));
            n_cmp++;
            if (ocw_ns !== model_cw(7'(c), 1'b0)) begin
                n_fail++;
                $display("FAIL unscrambled code=%h: got %h required %h", c, ocw_ns, model_cw(7'(c), 1'b0));
            end
            check_frame(7'(c), 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        logic [129:0] g_val, g_rdy, g_eop, x_val, x_rdy, x_eop;
        bit ok;
        ok = 1'b0;
        ival = 1'b1;
        idat = 7'h15;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (acc_last) ok = 1'b1;
        end
        idat = 7'h2A;
        for (int i = 0; i < 130; i++) begin
            g_val[i] = oval; g_rdy[i] = ordy; g_eop[i] = oeop;
            x_val[i] = (i < 128);
            x_rdy[i] = (i == 63) || (i >= 127);
            x_eop[i] = (i == 63) || (i == 127);
            tick();
            if (acc_last) ival = 1'b0;
        end
        ival = 1'b0;
        n_cmp++;
        if (!ok || g_val !== x_val) begin
            n_fail++;
            $display("FAIL b2b_val: got %h required %h", g_val, x_val);
        end
        n_cmp++;
        if (g_rdy !== x_rdy) begin
            n_fail++;
            $display("FAIL b2b_rdy: got %h required %h", g_rdy, x_rdy);
        end
        n_cmp++;
        if (g_eop !== x_eop) begin
            n_fail++;
            $display("FAIL b2b_eop: got %h required %h", g_eop, x_eop);
        end
        check_frame(7'h15, 1'b0);
        check_frame(7'h2A, 1'b1);
    endtask

    task automatic test_gated();
        logic [6:0] code;
        gate_on = 1'b1;
        inject  = 1'b1;
        for (int n = 0; n < 6; n++) begin
            code = 7'($urandom);
            send(code);
            check_frame(code, 1'b1);
        end
        gate_on = 1'b0;
        inject  = 1'b0;
        iclkena = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        send(7'h00);
        for (int i = 0; i < 200 && q.size() < 30; i++) tick();
        #2;
        rst  = 1'b1;
        #1;
        n_cmp++;
        if ({ordy, oval, oeop, osop} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got rdy/val/eop/sop=%b required 1000", {ordy, oval, oeop, osop});
        end
        ival = 1'b1;
        idat = 7'h55;
        tick(); tick();
        ival = 1'b0;
        rst  = 1'b0;
        q.delete();
        tick(); tick();
        n_cmp++;
        if ({ordy, oval} !== 2'b10 || q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_wins: got rdy/val=%b bits=%0d required 10 bits=0", {ordy, oval}, q.size());
        end
        send(7'h00);
        check_frame(7'h00, 1'b1);
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_all_codes();
        test_back_to_back();
        test_gated();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
